// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the irq_controller peripheral.
package irq_ctrl_pkg;

  localparam int NSRC              = 8;
  localparam int NMI_PULSE_DEFAULT = 4;

  localparam logic [1:0] IFR_ADDR    = 2'd0;
  localparam logic [1:0] IER_ADDR    = 2'd1;
  localparam logic [1:0] EDGE_ADDR   = 2'd2;
  localparam logic [1:0] NMISEL_ADDR = 2'd3;

  typedef enum logic [1:0] {
    NMI_IDLE = 2'd0,
    NMI_LOW  = 2'd1,
    NMI_GAP  = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/irq_controller_nmi_pulse_gen.sv
// Turns rising edges of nmi_req into fixed-width active-low NMI pulses,
// queueing at most one extra request that arrives while a pulse is running.
module nmi_pulse_gen
  import irq_ctrl_pkg::*;
#(
  parameter int NMI_PULSE = NMI_PULSE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic nmi_req,
  output logic nmi_n
);

  localparam logic [7:0] CNT_LOAD = 8'(NMI_PULSE - 1);

  nmi_state_e state;
  logic [7:0] cnt;
  logic       req_prev;
  logic       pending;
  logic       rise;

  assign rise = nmi_req & ~req_prev;

  // NMI_GAP always lasts one cycle so back-to-back pulses show a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NMI_IDLE;
      cnt      <= '0;
      req_prev <= 1'b0;
      pending  <= 1'b0;
      nmi_n    <= 1'b1;
    end else begin
      req_prev <= nmi_req;
      case (state)
        NMI_IDLE: begin
          if (rise) begin
            state <= NMI_LOW;
            cnt   <= CNT_LOAD;
            nmi_n <= 1'b0;
          end
        end
        NMI_LOW: begin
          if (rise) pending <= 1'b1;
          if (cnt == '0) begin
            state <= NMI_GAP;
            nmi_n <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        NMI_GAP: begin
          if (pending | rise) begin
            state   <= NMI_LOW;
            cnt     <= CNT_LOAD;
            nmi_n   <= 1'b0;
            pending <= 1'b0;
          end else begin
            state <= NMI_IDLE;
          end
        end
        default: begin
          state <= NMI_IDLE;
          nmi_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Four-register interrupt controller: synchronises eight sources into W1C flags
// and drives the CPU's level irq_n and pulsed nmi_n.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NMI_PULSE = NMI_PULSE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            cs,
  input  logic            rw,
  input  logic [1:0]      addr,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            irq_n,
  output logic            nmi_n
);

  logic [NSRC-1:0] sync1, s, s_prev;
  logic [NSRC-1:0] ifr, ier, edge_mode, nmisel;
  logic [NSRC-1:0] set, clr;
  logic            wr, rd, nmi_req;

  assign wr      = cs & ~rw;
  assign rd      = cs & rw;
  assign set     = (edge_mode & s & ~s_prev) | (~edge_mode & s);
  assign clr     = (wr && addr == IFR_ADDR) ? wdata : '0;
  assign nmi_req = |(ifr & ier & nmisel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      sync1  <= src;
      s      <= sync1;
      s_prev <= s;
    end
  end

  // A set in the same cycle as a W1C clear wins, so live level sources stay flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifr       <= '0;
      ier       <= '0;
      edge_mode <= '0;
      nmisel    <= '0;
    end else begin
      ifr <= set | (ifr & ~clr);
      if (wr && addr == IER_ADDR)    ier       <= wdata;
      if (wr && addr == EDGE_ADDR)   edge_mode <= wdata;
      if (wr && addr == NMISEL_ADDR) nmisel    <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~|(ifr & ier & ~nmisel);
      if (rd) begin
        case (addr)
          IFR_ADDR:    rdata <= ifr;
          IER_ADDR:    rdata <= ier;
          EDGE_ADDR:   rdata <= edge_mode;
          NMISEL_ADDR: rdata <= nmisel;
          default:     rdata <= '0;
        endcase
      end
    end
  end

  nmi_pulse_gen #(
    .NMI_PULSE(NMI_PULSE)
  ) u_nmi (
    .clk    (clk),
    .reset  (reset),
    .nmi_req(nmi_req),
    .nmi_n  (nmi_n)
  );

endmodule
